// File: rtl/divergence_branch_unit.sv
// divergence_branch_unit
// Splits the active lane mask on a resolved branch. On divergence it pushes the
// fall-through context to the divergence context queue and redirects fetch to the
// taken path. When the active warp finishes, it pops the oldest saved context and
// redirects fetch to it, or signals warp completion if the queue is empty.
//
// Ports:
//   clk, reset                    core clock, synchronous active-high reset
//   br_valid/br_ready             resolved branch handshake (br_ready also gates done_valid)
//   br_cond_mask, br_exec_mask    per-lane taken condition, current active mask
//   br_pc_taken, br_pc_fall       branch target and fall-through PC
//   br_regs                       current register set
//   done_valid                    active warp reached end / reconvergence point
//   q_full, q_empty, q_back_*     context queue status and oldest entry
//   q_push, q_push_*              push request and context data
//   q_pop                         advance queue read position
//   redir_*                       one-cycle fetch redirect (pc, mask, optional regs restore)
//   all_done                      one-cycle pulse: warp and queue both exhausted
//   err_sticky                    branch and done presented together; cleared by reset
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready to accept a branch or a done indication
// PUSH     | offering the fall-through context to the queue, waits on q_full
// REDIRECT | driving the latched fetch redirect for one cycle
// POP      | consuming the oldest queued context, latching it as redirect
// HALTED   | warp and queue exhausted, everything ignored until reset

module divergence_branch_unit #(
   parameter int NUM_LANES = 8,
   parameter int PC_W      = 32,
   parameter int REGS_W    = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 br_valid,
   output logic                 br_ready,
   input  logic [NUM_LANES-1:0] br_cond_mask,
   input  logic [NUM_LANES-1:0] br_exec_mask,
   input  logic [PC_W-1:0]      br_pc_taken,
   input  logic [PC_W-1:0]      br_pc_fall,
   input  logic [REGS_W-1:0]    br_regs,
   input  logic                 done_valid,
   input  logic                 q_full,
   input  logic                 q_empty,
   input  logic [PC_W-1:0]      q_back_pc,
   input  logic [NUM_LANES-1:0] q_back_mask,
   input  logic [REGS_W-1:0]    q_back_regs,
   output logic                 q_push,
   output logic [PC_W-1:0]      q_push_pc,
   output logic [NUM_LANES-1:0] q_push_mask,
   output logic [REGS_W-1:0]    q_push_regs,
   output logic                 q_pop,
   output logic                 redir_valid,
   output logic [PC_W-1:0]      redir_pc,
   output logic [NUM_LANES-1:0] redir_mask,
   output logic                 redir_regs_load,
   output logic [REGS_W-1:0]    redir_regs,
   output logic                 all_done,
   output logic                 err_sticky
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH,
      S_REDIRECT,
      S_POP,
      S_HALTED
   } state_t;

   state_t state, state_nx;

   logic [NUM_LANES-1:0] taken_mask;
   logic [NUM_LANES-1:0] fall_mask;

   logic                 lat_push;
   logic                 lat_redir_uni;
   logic                 lat_redir_div;
   logic                 lat_redir_pop;
   logic                 set_err;
   logic                 halt_pulse;

   logic [PC_W-1:0]      push_pc_r;
   logic [NUM_LANES-1:0] push_mask_r;
   logic [REGS_W-1:0]    push_regs_r;
   logic [PC_W-1:0]      redir_pc_r;
   logic [NUM_LANES-1:0] redir_mask_r;
   logic                 redir_ld_r;
   logic [REGS_W-1:0]    redir_regs_r;
   logic                 all_done_r;
   logic                 err_r;

   assign taken_mask = br_cond_mask & br_exec_mask;
   assign fall_mask  = ~br_cond_mask & br_exec_mask;

   always_comb begin
      state_nx      = state;
      lat_push      = 1'b0;
      lat_redir_uni = 1'b0;
      lat_redir_div = 1'b0;
      lat_redir_pop = 1'b0;
      set_err       = 1'b0;
      halt_pulse    = 1'b0;
      case (state)
         S_IDLE: begin
            // done has priority; a simultaneous branch is dropped and flagged
            if (done_valid) begin
               set_err = br_valid;
               if (q_empty) begin
                  state_nx   = S_HALTED;
                  halt_pulse = 1'b1;
               end else begin
                  state_nx = S_POP;
               end
            end else if (br_valid) begin
               // an all-zero exec mask falls in the uniform-taken case
               if (fall_mask == '0) begin
                  lat_redir_uni = 1'b1;
                  state_nx      = S_REDIRECT;
               end else if (taken_mask != '0) begin
                  lat_push      = 1'b1;
                  lat_redir_div = 1'b1;
                  state_nx      = S_PUSH;
               end
            end
         end
         S_PUSH: begin
            if (!q_full) state_nx = S_REDIRECT;
         end
         S_REDIRECT: state_nx = S_IDLE;
         S_POP: begin
            lat_redir_pop = 1'b1;
            state_nx      = S_REDIRECT;
         end
         S_HALTED: state_nx = S_HALTED;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         push_pc_r    <= '0;
         push_mask_r  <= '0;
         push_regs_r  <= '0;
         redir_pc_r   <= '0;
         redir_mask_r <= '0;
         redir_ld_r   <= 1'b0;
         redir_regs_r <= '0;
         all_done_r   <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state      <= state_nx;
         all_done_r <= halt_pulse;
         if (set_err) err_r <= 1'b1;
         if (lat_push) begin
            push_pc_r   <= br_pc_fall;
            push_mask_r <= fall_mask;
            push_regs_r <= br_regs;
         end
         if (lat_redir_uni) begin
            redir_pc_r   <= br_pc_taken;
            redir_mask_r <= br_exec_mask;
            redir_ld_r   <= 1'b0;
         end
         if (lat_redir_div) begin
            redir_pc_r   <= br_pc_taken;
            redir_mask_r <= taken_mask;
            redir_ld_r   <= 1'b0;
         end
         if (lat_redir_pop) begin
            redir_pc_r   <= q_back_pc;
            redir_mask_r <= q_back_mask;
            redir_ld_r   <= 1'b1;
            redir_regs_r <= q_back_regs;
         end
      end
   end

   // data outputs are forced to zero outside their strobe cycle
   assign br_ready        = (state == S_IDLE);
   assign q_push          = (state == S_PUSH) && !q_full;
   assign q_push_pc       = q_push ? push_pc_r   : '0;
   assign q_push_mask     = q_push ? push_mask_r : '0;
   assign q_push_regs     = q_push ? push_regs_r : '0;
   assign q_pop           = (state == S_POP);
   assign redir_valid     = (state == S_REDIRECT);
   assign redir_pc        = redir_valid ? redir_pc_r   : '0;
   assign redir_mask      = redir_valid ? redir_mask_r : '0;
   assign redir_regs_load = redir_valid && redir_ld_r;
   assign redir_regs      = redir_regs_load ? redir_regs_r : '0;
   assign all_done        = all_done_r;
   assign err_sticky      = err_r;

endmodule

// File: tb/tb_divergence_branch_unit.sv
// Self-checking bench for divergence_branch_unit: directed steps, expected queue
// and fetch events queued when stimulus is driven, compared when the DUT emits them.

module tb_divergence_branch_unit;

   localparam int NL = 8;
   localparam int PW = 32;
   localparam int RW = 1024;

   localparam int K_PUSH  = 1;
   localparam int K_REDIR = 2;
   localparam int K_POP   = 3;
   localparam int K_DONE  = 4;

   logic          clk;
   logic          reset;
   logic          br_valid;
   logic          br_ready;
   logic [NL-1:0] br_cond_mask;
   logic [NL-1:0] br_exec_mask;
   logic [PW-1:0] br_pc_taken;
   logic [PW-1:0] br_pc_fall;
   logic [RW-1:0] br_regs;
   logic          done_valid;
   logic          q_full;
   logic          q_empty;
   logic [PW-1:0] q_back_pc;
   logic [NL-1:0] q_back_mask;
   logic [RW-1:0] q_back_regs;
   logic          q_push;
   logic [PW-1:0] q_push_pc;
   logic [NL-1:0] q_push_mask;
   logic [RW-1:0] q_push_regs;
   logic          q_pop;
   logic          redir_valid;
   logic [PW-1:0] redir_pc;
   logic [NL-1:0] redir_mask;
   logic          redir_regs_load;
   logic [RW-1:0] redir_regs;
   logic          all_done;
   logic          err_sticky;

   divergence_branch_unit #(.NUM_LANES(NL), .PC_W(PW), .REGS_W(RW)) dut (
      .clk             (clk),
      .reset           (reset),
      .br_valid        (br_valid),
      .br_ready        (br_ready),
      .br_cond_mask    (br_cond_mask),
      .br_exec_mask    (br_exec_mask),
      .br_pc_taken     (br_pc_taken),
      .br_pc_fall      (br_pc_fall),
      .br_regs         (br_regs),
      .done_valid      (done_valid),
      .q_full          (q_full),
      .q_empty         (q_empty),
      .q_back_pc       (q_back_pc),
      .q_back_mask     (q_back_mask),
      .q_back_regs     (q_back_regs),
      .q_push          (q_push),
      .q_push_pc       (q_push_pc),
      .q_push_mask     (q_push_mask),
      .q_push_regs     (q_push_regs),
      .q_pop           (q_pop),
      .redir_valid     (redir_valid),
      .redir_pc        (redir_pc),
      .redir_mask      (redir_mask),
      .redir_regs_load (redir_regs_load),
      .redir_regs      (redir_regs),
      .all_done        (all_done),
      .err_sticky      (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            kind;
      logic [PW-1:0] pc;
      logic [NL-1:0] mask;
      logic          ld;
      logic [RW-1:0] regs;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   logic [RW-1:0] pat_a;
   logic [RW-1:0] pat_b;
   logic [RW-1:0] pat_c;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [PW-1:0] pc, input logic [NL-1:0] mask,
                            input logic ld, input logic [RW-1:0] regs);
      exp_t e;
      e.kind = kind;
      e.pc   = pc;
      e.mask = mask;
      e.ld   = ld;
      e.regs = regs;
      sb.push_back(e);
   endtask

   // compares whatever the DUT emits right now against the oldest expectation
   task automatic mon();
      exp_t e;
      int   k;
      chk("push_pop_excl", 64'(q_push & q_pop), 64'd0);
      if (q_push | redir_valid | q_pop | all_done) begin
         k = q_push ? K_PUSH : q_pop ? K_POP : redir_valid ? K_REDIR : K_DONE;
         chk("sb_has_expect", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ev_kind", 64'(k), 64'(e.kind));
            if (k == K_PUSH) begin
               chk("push_pc", 64'(q_push_pc), 64'(e.pc));
               chk("push_mask", 64'(q_push_mask), 64'(e.mask));
               chk("push_regs_eq", 64'(q_push_regs === e.regs), 64'd1);
            end else if (k == K_REDIR) begin
               chk("redir_pc", 64'(redir_pc), 64'(e.pc));
               chk("redir_mask", 64'(redir_mask), 64'(e.mask));
               chk("redir_ld", 64'(redir_regs_load), 64'(e.ld));
               if (e.ld) chk("redir_regs_eq", 64'(redir_regs === e.regs), 64'd1);
            end
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      mon();
   endtask

   task automatic drive_br(input logic [NL-1:0] cond, input logic [NL-1:0] exec,
                           input logic [PW-1:0] pt, input logic [PW-1:0] pf,
                           input logic [RW-1:0] regs);
      logic [NL-1:0] tk;
      logic [NL-1:0] fl;
      br_valid     = 1'b1;
      br_cond_mask = cond;
      br_exec_mask = exec;
      br_pc_taken  = pt;
      br_pc_fall   = pf;
      br_regs      = regs;
      tk = cond & exec;
      fl = ~cond & exec;
      if (fl == '0) begin
         expect_ev(K_REDIR, pt, exec, 1'b0, '0);
      end else if (tk != '0) begin
         expect_ev(K_PUSH, pf, fl, 1'b0, regs);
         expect_ev(K_REDIR, pt, tk, 1'b0, '0);
      end
   endtask

   task automatic drive_done(input logic empty, input logic [PW-1:0] pc,
                             input logic [NL-1:0] mask, input logic [RW-1:0] regs);
      done_valid  = 1'b1;
      q_empty     = empty;
      q_back_pc   = pc;
      q_back_mask = mask;
      q_back_regs = regs;
      if (empty) begin
         expect_ev(K_DONE, '0, '0, 1'b0, '0);
      end else begin
         expect_ev(K_POP, '0, '0, 1'b0, '0);
         expect_ev(K_REDIR, pc, mask, 1'b1, regs);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < RW / 32; i++) begin
         pat_a[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
         pat_b[i*32 +: 32] = $urandom;
         pat_c[i*32 +: 32] = $urandom;
      end
      br_valid = 1'b0; br_cond_mask = '0; br_exec_mask = '0;
      br_pc_taken = '0; br_pc_fall = '0; br_regs = '0;
      done_valid = 1'b0; q_full = 1'b0; q_empty = 1'b1;
      q_back_pc = '0; q_back_mask = '0; q_back_regs = '0;
      reset = 1'b1;
      do_reset();
      cyc();

      // reset state
      chk("rst_br_ready", 64'(br_ready), 64'd1);
      chk("rst_q_push", 64'(q_push), 64'd0);
      chk("rst_q_pop", 64'(q_pop), 64'd0);
      chk("rst_redir_valid", 64'(redir_valid), 64'd0);
      chk("rst_all_done", 64'(all_done), 64'd0);
      chk("rst_err", 64'(err_sticky), 64'd0);

      // uniform taken
      drive_br(8'hFF, 8'hFF, 32'h100, 32'h104, pat_b);
      cyc();
      br_valid = 1'b0;
      chk("uni_redir_n1", 64'(redir_valid), 64'd1);
      chk("uni_no_push", 64'(q_push), 64'd0);
      cyc();
      chk("uni_back_idle", 64'(br_ready), 64'd1);
      chk("uni_drained", 64'(sb.size()), 64'd0);

      // divergent, queue has room
      drive_br(8'h0F, 8'hFF, 32'h200, 32'h204, pat_b);
      cyc();
      br_valid = 1'b0;
      chk("div_push_n1", 64'(q_push), 64'd1);
      chk("div_busy", 64'(br_ready), 64'd0);
      cyc();
      chk("div_redir_n2", 64'(redir_valid), 64'd1);
      cyc();
      chk("div_drained", 64'(sb.size()), 64'd0);

      // uniform fall-through: no action
      drive_br(8'h00, 8'hFF, 32'h280, 32'h284, pat_b);
      cyc();
      br_valid = 1'b0;
      chk("fall_no_redir", 64'(redir_valid), 64'd0);
      chk("fall_no_push", 64'(q_push), 64'd0);
      chk("fall_ready", 64'(br_ready), 64'd1);

      // empty exec mask counts as uniform taken
      drive_br(8'hAA, 8'h00, 32'h300, 32'h304, pat_b);
      cyc();
      br_valid = 1'b0;
      chk("exec0_redir", 64'(redir_valid), 64'd1);
      cyc();
      chk("exec0_drained", 64'(sb.size()), 64'd0);

      // divergent with queue full for 5 cycles
      q_full = 1'b1;
      drive_br(8'h33, 8'hFF, 32'h400, 32'h404, pat_c);
      for (int i = 0; i < 5; i++) begin
         cyc();
         br_valid = 1'b0;
         chk("full_no_push", 64'(q_push), 64'd0);
         chk("full_not_ready", 64'(br_ready), 64'd0);
      end
      q_full = 1'b0;
      #1;
      mon();
      chk("full_push_on_drop", 64'(q_push), 64'd1);
      cyc();
      chk("full_redir_next", 64'(redir_valid), 64'd1);
      cyc();
      chk("full_drained", 64'(sb.size()), 64'd0);

      // done with a saved context
      drive_done(1'b0, 32'h204, 8'hF0, pat_a);
      cyc();
      done_valid = 1'b0;
      chk("pop_n1", 64'(q_pop), 64'd1);
      chk("pop_busy", 64'(br_ready), 64'd0);
      cyc();
      chk("pop_redir_n2", 64'(redir_valid), 64'd1);
      chk("pop_regs_load", 64'(redir_regs_load), 64'd1);
      cyc();

      // done with empty queue -> halted
      drive_done(1'b1, '0, '0, '0);
      cyc();
      done_valid = 1'b0;
      chk("halt_all_done", 64'(all_done), 64'd1);
      chk("halt_not_ready", 64'(br_ready), 64'd0);
      br_valid = 1'b1;
      br_cond_mask = 8'hFF; br_exec_mask = 8'hFF;
      cyc();
      chk("halt_pulse_one", 64'(all_done), 64'd0);
      chk("halt_still_busy", 64'(br_ready), 64'd0);
      cyc();
      chk("halt_ignore_br", 64'(redir_valid), 64'd0);
      br_valid = 1'b0;
      chk("halt_drained", 64'(sb.size()), 64'd0);

      // branch and done together: done wins, error flagged
      do_reset();
      br_valid = 1'b1;
      br_cond_mask = 8'hFF; br_exec_mask = 8'hFF; br_pc_taken = 32'h777;
      drive_done(1'b0, 32'h500, 8'h3C, pat_b);
      cyc();
      br_valid = 1'b0;
      done_valid = 1'b0;
      chk("both_pop", 64'(q_pop), 64'd1);
      chk("both_err", 64'(err_sticky), 64'd1);
      cyc();
      chk("both_redir", 64'(redir_valid), 64'd1);
      cyc();
      chk("both_err_sticky", 64'(err_sticky), 64'd1);
      chk("both_drained", 64'(sb.size()), 64'd0);

      // reset while waiting in PUSH
      q_full = 1'b1;
      drive_br(8'h0F, 8'hFF, 32'h600, 32'h604, pat_c);
      cyc();
      br_valid = 1'b0;
      chk("rp_waiting", 64'(q_push), 64'd0);
      reset = 1'b1;
      sb.delete();
      cyc();
      reset = 1'b0;
      q_full = 1'b0;
      #1;
      mon();
      chk("rp_no_push", 64'(q_push), 64'd0);
      chk("rp_ready", 64'(br_ready), 64'd1);
      chk("rp_err_clr", 64'(err_sticky), 64'd0);
      chk("rp_push_pc_zero", 64'(q_push_pc), 64'd0);
      cyc();
      chk("rp_no_push2", 64'(q_push), 64'd0);
      chk("rp_no_redir", 64'(redir_valid), 64'd0);
      cyc();
      chk("rp_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divergence_branch_unit.md
Name: divergence_branch_unit

Overview:
- Sits between the execute stage and the per-core divergence context queue.
- On a resolved branch it splits the active execution mask into taken and fall-through subsets.
- On divergence it pushes the fall-through context (PC, mask, register set) into the queue and redirects fetch to the taken path.
- When the active warp finishes, it pops the oldest saved context and redirects fetch to it; if the queue is empty it signals warp completion.

Parameters:
- NUM_LANES, 8, width of execution mask (one bit per lane).
- PC_W, 32, memory address width.
- REGS_W, 1024, flattened register-set width (32 regs x 32 bits).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- br_valid  in  1  resolved branch presented by execute.
- br_ready  out  1  unit can accept br_valid / done_valid this cycle.
- br_cond_mask  in  NUM_LANES  per-lane branch condition (1 = taken).
- br_exec_mask  in  NUM_LANES  current active mask.
- br_pc_taken  in  PC_W  branch target.
- br_pc_fall  in  PC_W  fall-through PC.
- br_regs  in  REGS_W  current register set.
- done_valid  in  1  active warp has reached end or reconvergence point.
- q_full  in  1  queue cannot take a push.
- q_empty  in  1  queue holds no contexts.
- q_back_pc  in  PC_W  PC of oldest saved context.
- q_back_mask  in  NUM_LANES  mask of oldest saved context.
- q_back_regs  in  REGS_W  register set of oldest saved context.
- q_push  out  1  push pc/mask/regs and advance write position.
- q_push_pc  out  PC_W  context PC to push.
- q_push_mask  out  NUM_LANES  context mask to push.
- q_push_regs  out  REGS_W  context register set to push.
- q_pop  out  1  advance read position.
- redir_valid  out  1  one-cycle fetch redirect.
- redir_pc  out  PC_W  redirect PC.
- redir_mask  out  NUM_LANES  new active mask.
- redir_regs_load  out  1  fetch must restore redir_regs.
- redir_regs  out  REGS_W  register set to restore.
- all_done  out  1  one-cycle pulse: warp and queue both exhausted.
- err_sticky  out  1  protocol violation seen; cleared only by reset.

Behaviour:
- Reset: state IDLE; all outputs 0 except br_ready=1. Reset mid-operation drops any pending push, pop or redirect.
- States: IDLE, PUSH, REDIRECT, POP, HALTED.
- br_ready = (state==IDLE). Inputs are sampled only when br_ready is high.
- IDLE, br_valid accepted:
  - Compute taken = cond & exec and fall = ~cond & exec.
  - fall==0 (uniform taken, including exec==0): latch redirect to (br_pc_taken, exec, no regs load), go REDIRECT.
  - taken==0: uniform fall-through, no action, stay IDLE.
  - Otherwise (divergent): latch push context (br_pc_fall, fall, br_regs) and redirect (br_pc_taken, taken), go PUSH.
- PUSH:
  - If q_full, hold with q_push=0 indefinitely.
  - Else q_push=1 for exactly one cycle with latched data, then go REDIRECT.
- REDIRECT: redir_valid=1 for one cycle with latched values, then go IDLE.
- IDLE, done_valid accepted:
  - q_empty=1: all_done pulses next cycle, go HALTED.
  - Else go POP.
- POP:
  - Sample q_back_* and assert q_pop=1 for one cycle.
  - Latch redirect (q_back_pc, q_back_mask, redir_regs_load=1, q_back_regs), go REDIRECT.
- HALTED: br_ready=0; all inputs ignored until reset.
- br_valid and done_valid together: done wins, branch is dropped, err_sticky set.
- Latency from accept at cycle N:
  - uniform taken: redir_valid at N+1.
  - divergent with q_full=0: q_push at N+1, redir_valid at N+2.
  - done with queue non-empty: q_pop at N+1, redir_valid at N+2.
  - done with queue empty: all_done at N+1.
- q_push and q_pop are never asserted in the same cycle.
- redir_regs_load=0 on every non-pop redirect.

Test Plan:
- Reset, then exec=8'hFF, cond=8'hFF, pc_taken=0x100 -> redir_valid at N+1, pc=0x100, mask=0xFF, no q_push.
- exec=0xFF, cond=0x0F, pc_taken=0x200, pc_fall=0x204 -> q_push at N+1 with pc=0x204, mask=0xF0; redir at N+2 with pc=0x200, mask=0x0F.
- Divergent branch with q_full=1 for 5 cycles -> q_push=0 and br_ready=0 throughout; push in the cycle q_full drops; redirect the next cycle.
- done_valid with q_empty=0, back pc=0x204, mask=0xF0, regs=pattern A -> q_pop at N+1; redir at N+2 with regs_load=1 and regs=A. Then done_valid with q_empty=1 -> all_done pulse and br_ready stays 0.
- br_valid and done_valid both high -> branch ignored, err_sticky=1. Reset asserted during PUSH -> no q_push, all outputs 0, err_sticky=0.
